mu0_mode_reg: RTL and testbench

MU0_MODE_REG -- requirements
Module: mu0_mode_reg

---
 rtl/mu0_pkg.sv | 15 +
 rtl/mu0_reg_alu.sv | 63 ++++++
 rtl/mu0_mode_reg.sv | 49 ++++
 tb/tb_mu0_mode_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared types for the MU0 mode register: operation encodings used by the top and its ALU.
package mu0_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_INC  = 3'b010,
        MODE_DEC  = 3'b011,
        MODE_SHL  = 3'b100,
        MODE_SHR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

endpackage

// File: rtl/mu0_reg_alu.sv
// Combinational next-value and carry logic for the mode register.
// Inputs a mode does not select never reach the result mux, so X on them cannot leak into q_next.
module mu0_reg_alu
    import mu0_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int STEP  = 1,
    parameter int SAT   = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             carry,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             carry_next
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, q} + STEP_W;
    // Top bit of the extended difference is the borrow, since STEP < 2^WIDTH.
    assign diff = {1'b0, q} - STEP_W;

    always_comb begin
        q_next     = q;
        carry_next = carry;
        case (mode)
            MODE_LOAD: begin
                q_next     = d;
                carry_next = 1'b0;
            end
            MODE_INC: begin
                carry_next = sum[WIDTH];
                q_next     = (sum[WIDTH] && SAT != 0) ? '1 : sum[WIDTH-1:0];
            end
            MODE_DEC: begin
                carry_next = diff[WIDTH];
                q_next     = (diff[WIDTH] && SAT != 0) ? '0 : diff[WIDTH-1:0];
            end
            MODE_SHL: begin
                q_next     = {q[WIDTH-2:0], ser_in};
                carry_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next     = {ser_in, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            MODE_CLR: begin
                q_next     = '0;
                carry_next = 1'b0;
            end
            default: begin
                q_next     = q;
                carry_next = carry;
            end
        endcase
    end

endmodule

// File: rtl/mu0_mode_reg.sv
// MU0 mode register: Q/Carry flops with enable gating and a combinational zero flag.
module mu0_mode_reg
    import mu0_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int STEP  = 1,
    parameter int SAT   = 0
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             En,
    input  mode_t            Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             Carry,
    output logic             Zero
);

    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    mu0_reg_alu #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SAT   (SAT)
    ) u_alu (
        .q          (Q),
        .carry      (Carry),
        .mode       (Mode),
        .d          (D),
        .ser_in     (SerIn),
        .q_next     (q_next),
        .carry_next (carry_next)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Q     <= '0;
            Carry <= 1'b0;
        end else if (En) begin
            Q     <= q_next;
            Carry <= carry_next;
        end
    end

    assign Zero = (Q == '0);

endmodule

// File: tb/tb_mu0_mode_reg.sv
// Scoreboard bench: two instances (wrap STEP=1, saturate STEP=4) share stimulus; expectations are queued and checked by a monitor.
module tb_mu0_mode_reg;
    import mu0_pkg::*;

    logic        Clk;
    logic        nReset;
    logic        En;
    mode_t       Mode;
    logic [11:0] D;
    logic        SerIn;
    logic [11:0] qa, qb;
    logic        ca, cb, za, zb;

    typedef struct {
        int          sel;
        logic [11:0] q;
        logic        c;
        logic        z;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    mu0_mode_reg #(.WIDTH(12), .STEP(1), .SAT(0)) dut_a (
        .Clk(Clk), .nReset(nReset), .En(En), .Mode(Mode), .D(D), .SerIn(SerIn),
        .Q(qa), .Carry(ca), .Zero(za)
    );

    mu0_mode_reg #(.WIDTH(12), .STEP(4), .SAT(1)) dut_b (
        .Clk(Clk), .nReset(nReset), .En(En), .Mode(Mode), .D(D), .SerIn(SerIn),
        .Q(qb), .Carry(cb), .Zero(zb)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void expect_v(int sel, logic [11:0] q, logic c, string name);
        exp_t e;
        e.sel  = sel;
        e.q    = q;
        e.c    = c;
        e.z    = (q == 12'h000);
        e.name = name;
        exp_q.push_back(e);
    endfunction

    task automatic drive(logic en, mode_t m, logic [11:0] d, logic ser);
        @(negedge Clk);
        En    = en;
        Mode  = m;
        D     = d;
        SerIn = ser;
    endtask

    // Monitor: after each clock edge or reset assertion, settle then check everything queued.
    initial begin
        exp_t        e;
        logic [11:0] aq;
        logic        ac, az;
        forever begin
            @(posedge Clk or negedge nReset);
            #1;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                aq = (e.sel == 0) ? qa : qb;
                ac = (e.sel == 0) ? ca : cb;
                az = (e.sel == 0) ? za : zb;
                n_total++;
                if (aq === e.q && ac === e.c && az === e.z)
                    n_pass++;
                else
                    $display("FAIL %s: got Q=%h Carry=%b Zero=%b, want Q=%h Carry=%b Zero=%b",
                             e.name, aq, ac, az, e.q, e.c, e.z);
            end
        end
    end

    initial begin
        nReset = 1'b0;
        En     = 1'b0;
        Mode   = MODE_HOLD;
        D      = 12'h000;
        SerIn  = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        nReset = 1'b1;

        drive(1'b0, MODE_HOLD, 12'h000, 1'b0);
        expect_v(0, 12'h000, 1'b0, "rst_state_a");
        expect_v(1, 12'h000, 1'b0, "rst_state_b");

        drive(1'b1, MODE_LOAD, 12'h5A5, 1'b0);
        expect_v(0, 12'h5A5, 1'b0, "load_5a5");

        // Asynchronous reset mid-cycle, no clock edge before the check.
        @(negedge Clk);
        En = 1'b0;
        expect_v(0, 12'h000, 1'b0, "async_rst_a");
        expect_v(1, 12'h000, 1'b0, "async_rst_b");
        #1 nReset = 1'b0;
        @(negedge Clk);
        En   = 1'b1;
        Mode = MODE_LOAD;
        D    = 12'h777;
        @(negedge Clk);
        En     = 1'b0;
        nReset = 1'b1;

        drive(1'b0, MODE_LOAD, 12'h111, 1'b0);
        expect_v(0, 12'h000, 1'b0, "load_en0");
        drive(1'b1, MODE_LOAD, 12'h111, 1'b0);
        expect_v(0, 12'h111, 1'b0, "load_111");

        drive(1'b1, MODE_LOAD, 12'hFFF, 1'b0);
        expect_v(0, 12'hFFF, 1'b0, "load_fff");
        drive(1'b1, MODE_INC, 12'hxxx, 1'bx);
        expect_v(0, 12'h000, 1'b1, "inc_wrap");
        drive(1'b1, MODE_DEC, 12'hxxx, 1'bx);
        expect_v(0, 12'hFFF, 1'b1, "dec_wrap");
        drive(1'b1, MODE_HOLD, 12'hxxx, 1'bx);
        expect_v(0, 12'hFFF, 1'b1, "hold");
        drive(1'b1, MODE_RSVD, 12'hxxx, 1'bx);
        expect_v(0, 12'hFFF, 1'b1, "reserved");
        drive(1'b0, MODE_CLR, 12'h000, 1'b0);
        expect_v(0, 12'hFFF, 1'b1, "clr_en0");

        drive(1'b1, MODE_LOAD, 12'h801, 1'b0);
        expect_v(0, 12'h801, 1'b0, "load_801");
        drive(1'b1, MODE_SHL, 12'hxxx, 1'b1);
        expect_v(0, 12'h003, 1'b1, "shl");
        drive(1'b1, MODE_SHR, 12'hxxx, 1'b0);
        expect_v(0, 12'h001, 1'b1, "shr");
        drive(1'b1, MODE_CLR, 12'hxxx, 1'bx);
        expect_v(0, 12'h000, 1'b0, "clr");
        drive(1'b1, MODE_DEC, 12'hxxx, 1'bx);
        expect_v(0, 12'hFFF, 1'b1, "dec_from_zero");

        drive(1'b1, MODE_LOAD, 12'hFFE, 1'b0);
        expect_v(1, 12'hFFE, 1'b0, "sat_load_ffe");
        drive(1'b1, MODE_INC, 12'hxxx, 1'bx);
        expect_v(0, 12'hFFF, 1'b0, "inc_no_carry");
        expect_v(1, 12'hFFF, 1'b1, "sat_inc");
        drive(1'b1, MODE_LOAD, 12'h002, 1'b0);
        expect_v(1, 12'h002, 1'b0, "sat_load_002");
        drive(1'b1, MODE_DEC, 12'hxxx, 1'bx);
        expect_v(0, 12'h001, 1'b0, "dec_no_borrow");
        expect_v(1, 12'h000, 1'b1, "sat_dec");
        drive(1'b1, MODE_LOAD, 12'h010, 1'b0);
        drive(1'b1, MODE_INC, 12'hxxx, 1'bx);
        expect_v(1, 12'h014, 1'b0, "step4_inc");
        drive(1'b1, MODE_DEC, 12'hxxx, 1'bx);
        expect_v(1, 12'h010, 1'b0, "step4_dec");

        drive(1'b0, MODE_HOLD, 12'h000, 1'b0);
        repeat (3) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
